// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: ALU results win the single write port; LSU results queue in a small FIFO.
// Optional macro WB_BYPASS_EN lets an LSU result skip the empty FIFO straight to the write port.
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int LQ_DEPTH = 2,
  parameter int CW       = $clog2(LQ_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            RegWEn,
  output logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_data,
  input  logic [AW-1:0]   chk_addr,
  output logic            chk_hit,
  output logic [CW-1:0]   lq_count
);

  localparam int PW = $clog2(LQ_DEPTH);

  logic [AW-1:0]       r_q_rd   [LQ_DEPTH];
  logic [XLEN-1:0]     r_q_data [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] r_q_vld;
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic                r_wen;
  logic [AW-1:0]       r_addr;
  logic [XLEN-1:0]     r_data;

  logic                w_alu_eff;
  logic                w_ready;
  logic                w_lsu_eff;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_bypass;
  logic                w_q_hit;
  logic [LQ_DEPTH-1:0] w_push_mask;
  logic [LQ_DEPTH-1:0] w_pop_mask;

  // Ready is a function of registered occupancy only, so nothing loops back from lsu_valid.
  assign w_ready   = !rst && (r_count != CW'(LQ_DEPTH));
  assign w_alu_eff = alu_valid && (alu_rd != {AW{1'b0}});
  assign w_lsu_eff = lsu_valid && w_ready && (lsu_rd != {AW{1'b0}});
  assign w_empty   = (r_count == {CW{1'b0}});
  assign w_pop     = !w_alu_eff && !w_empty;

`ifdef WB_BYPASS_EN
  assign w_bypass = w_lsu_eff && w_empty && !w_alu_eff;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_lsu_eff && !w_bypass;

  // Per-entry valid masks; a push never targets the slot being popped (full blocks push, empty blocks pop).
  always_comb begin
    w_push_mask = {LQ_DEPTH{1'b0}};
    w_pop_mask  = {LQ_DEPTH{1'b0}};
    for (int i = 0; i < LQ_DEPTH; i++) begin
      w_push_mask[i] = w_push && (r_wptr == PW'(i));
      w_pop_mask[i]  = w_pop  && (r_rptr == PW'(i));
    end
  end

  // Hazard query over queued entries plus the write that lands at the next edge.
  always_comb begin
    w_q_hit = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      w_q_hit = w_q_hit | (r_q_vld[i] && (r_q_rd[i] == chk_addr));
    end
    chk_hit = (chk_addr != {AW{1'b0}}) && (w_q_hit || (r_wen && (r_addr == chk_addr)));
  end

  // Queue storage: payload needs no reset because r_q_vld qualifies every entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wptr]   <= lsu_rd;
      r_q_data[r_wptr] <= lsu_data;
    end else begin
      r_q_rd[r_wptr]   <= r_q_rd[r_wptr];
      r_q_data[r_wptr] <= r_q_data[r_wptr];
    end
  end

  // Queue control: pointers, valid bits and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_q_vld <= {LQ_DEPTH{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      r_wptr  <= w_push ? r_wptr + PW'(1) : r_wptr;
      r_rptr  <= w_pop  ? r_rptr + PW'(1) : r_rptr;
      r_q_vld <= (r_q_vld & ~w_pop_mask) | w_push_mask;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write-port register: ALU, then queue head, then bypassed LSU; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen  <= 1'b0;
      r_addr <= {AW{1'b0}};
      r_data <= {XLEN{1'b0}};
    end else if (w_alu_eff) begin
      r_wen  <= 1'b1;
      r_addr <= alu_rd;
      r_data <= alu_data;
    end else if (w_pop) begin
      r_wen  <= 1'b1;
      r_addr <= r_q_rd[r_rptr];
      r_data <= r_q_data[r_rptr];
    end else if (w_bypass) begin
      r_wen  <= 1'b1;
      r_addr <= lsu_rd;
      r_data <= lsu_data;
    end else begin
      r_wen  <= 1'b0;
      r_addr <= r_addr;
      r_data <= r_data;
    end
  end

  assign lsu_ready = w_ready;
  assign RegWEn    = r_wen;
  assign rd_addr   = r_addr;
  assign rd_data   = r_data;
  assign lq_count  = r_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (default parameters, either WB_BYPASS_EN setting).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        RegWEn;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  chk_addr;
  logic        chk_hit;
  logic [1:0]  lq_count;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .RegWEn(RegWEn), .rd_addr(rd_addr), .rd_data(rd_data),
    .chk_addr(chk_addr), .chk_hit(chk_hit), .lq_count(lq_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic wen, input logic [4:0] addr, input logic [31:0] data);
    chk({tag, "_wen"},  {31'd0, RegWEn}, {31'd0, wen});
    chk({tag, "_addr"}, {27'd0, rd_addr}, {27'd0, addr});
    chk({tag, "_data"}, rd_data, data);
  endtask

  logic [4:0]  e_rd   [10];
  logic [31:0] e_data [10];
  int          n_acc;
  int          n_ret;
  logic        acc_now;
  logic        prev_alu;
  logic [4:0]  prev_rd;
  logic [31:0] prev_data;

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_7777; chk_addr = 5'd0;

    // Reset held two cycles with an LSU offer present.
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst_ready", {31'd0, lsu_ready}, 32'd0);
      chk_port("rst", 1'b0, 5'd0, 32'd0);
      chk("rst_count", {30'd0, lq_count}, 32'd0);
    end
    rst = 1'b0; lsu_valid = 1'b0;
    #1;
    chk("rel_ready", {31'd0, lsu_ready}, 32'd1);

    // ALU path: one-cycle latency, then idle.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
    tick;
    alu_valid = 1'b0;
    chk_port("alu", 1'b1, 5'd5, 32'h0000_1234);
    tick;
    chk_port("alu_idle", 1'b0, 5'd5, 32'h0000_1234);

    // ALU priority with LSU backpressure.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_AAAA;
    tick;
    chk("pri_cnt1", {30'd0, lq_count}, 32'd1);
    alu_rd = 5'd2; alu_data = 32'h22; lsu_rd = 5'd8; lsu_data = 32'h0000_BBBB;
    #1;
    chk("pri_ready1", {31'd0, lsu_ready}, 32'd1);
    tick;
    chk_port("pri_x2", 1'b1, 5'd2, 32'h22);
    chk("pri_cnt2", {30'd0, lq_count}, 32'd2);
    chk("pri_full_ready", {31'd0, lsu_ready}, 32'd0);
    alu_rd = 5'd3; alu_data = 32'h33; lsu_rd = 5'd9; lsu_data = 32'h0000_CCCC;
    tick;
    chk("pri_stall_cnt", {30'd0, lq_count}, 32'd2);
    alu_rd = 5'd4; alu_data = 32'h44;
    tick;
    chk_port("pri_x4", 1'b1, 5'd4, 32'h44);
    chk("pri_stall_ready", {31'd0, lsu_ready}, 32'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0; chk_addr = 5'd8;
    #1;
    chk("pri_hit8", {31'd0, chk_hit}, 32'd1);
    tick;
    chk_port("pri_pop7", 1'b1, 5'd7, 32'h0000_AAAA);
    chk("pri_cnt_pop1", {30'd0, lq_count}, 32'd1);
    tick;
    chk_port("pri_pop8", 1'b1, 5'd8, 32'h0000_BBBB);
    chk("pri_cnt_pop2", {30'd0, lq_count}, 32'd0);
    tick;
    chk("pri_done_wen", {31'd0, RegWEn}, 32'd0);

    // x0 filtering on both sides.
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h10;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    tick;
    chk("x0_cnt", {30'd0, lq_count}, 32'd1);
    alu_rd = 5'd0; alu_data = 32'hDEAD; lsu_valid = 1'b0;
    tick;
    chk_port("x0_alu_pop", 1'b1, 5'd9, 32'h99);
    alu_valid = 1'b0; lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hBEEF;
    #1;
    chk("x0_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    tick;
    lsu_valid = 1'b0;
    chk_port("x0_lsu", 1'b0, 5'd9, 32'h99);
    chk("x0_lsu_cnt", {30'd0, lq_count}, 32'd0);

    // Hazard query across queue and output register.
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'h12C;
    tick;
    lsu_valid = 1'b0; alu_rd = 5'd14; alu_data = 32'hE;
    chk_addr = 5'd12; #1;
    chk("hz_q12", {31'd0, chk_hit}, 32'd1);
    chk_addr = 5'd13; #1;
    chk("hz_q13", {31'd0, chk_hit}, 32'd0);
    chk_addr = 5'd0; #1;
    chk("hz_x0", {31'd0, chk_hit}, 32'd0);
    chk_addr = 5'd12;
    tick;
    alu_valid = 1'b0;
    chk("hz_hold12", {31'd0, chk_hit}, 32'd1);
    tick;
    chk_port("hz_pop12", 1'b1, 5'd12, 32'h12C);
    chk("hz_out12", {31'd0, chk_hit}, 32'd1);
    tick;
    chk("hz_clear", {31'd0, chk_hit}, 32'd0);

    // LSU latency with empty queue and no ALU traffic.
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h55;
    tick;
    lsu_valid = 1'b0;
`ifdef WB_BYPASS_EN
    chk_port("byp_1cyc", 1'b1, 5'd3, 32'h55);
    chk("byp_cnt", {30'd0, lq_count}, 32'd0);
`else
    chk("nobyp_wen0", {31'd0, RegWEn}, 32'd0);
    chk("nobyp_cnt", {30'd0, lq_count}, 32'd1);
    tick;
    chk_port("nobyp_2cyc", 1'b1, 5'd3, 32'h55);
`endif
    tick;

    // Ten LSU entries through the queue under random ALU interference (ALU uses x0..x15 only).
    for (int i = 0; i < 10; i++) begin
      e_rd[i]   = 5'(16 + i);
      e_data[i] = 32'hA000 + i;
    end
    n_acc = 0; n_ret = 0;
    for (int cyc = 0; cyc < 80 && n_ret < 10; cyc++) begin
      alu_valid = (cyc < 40) && ($urandom_range(0, 99) < 60);
      alu_rd    = 5'($urandom_range(0, 15));
      alu_data  = $urandom;
      lsu_valid = (n_acc < 10);
      lsu_rd    = 5'(16 + n_acc);
      lsu_data  = 32'hA000 + n_acc;
      #1;
      acc_now   = lsu_valid && lsu_ready;
      prev_alu  = alu_valid && (alu_rd != 5'd0);
      prev_rd   = alu_rd;
      prev_data = alu_data;
      tick;
      if (acc_now) n_acc++;
      if (prev_alu) begin
        chk_port("wrap_alu", 1'b1, prev_rd, prev_data);
      end else if (RegWEn) begin
        if (n_ret < 10) begin
          chk("wrap_lsu_rd", {27'd0, rd_addr}, {27'd0, e_rd[n_ret]});
          chk("wrap_lsu_data", rd_data, e_data[n_ret]);
        end
        n_ret++;
      end
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk("wrap_accepted", n_acc, 32'd10);
    chk("wrap_retired", n_ret, 32'd10);
    tick;
    chk("wrap_no_dup", {31'd0, RegWEn}, 32'd0);
    chk("wrap_empty", {30'd0, lq_count}, 32'd0);

    // Reset mid-operation discards queued entries.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h20;
    tick;
    alu_valid = 1'b0; lsu_valid = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_port("mid_rst", 1'b0, 5'd0, 32'd0);
    chk("mid_rst_cnt", {30'd0, lq_count}, 32'd0);
    tick;
    chk("mid_rst_nopop", {31'd0, RegWEn}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side driver for the 32x32 register file. Merges single-cycle ALU results with multi-cycle load/store unit (LSU) results into the file's single write port: RegWEn, rd_addr, rd_data.
- LSU results wait in a small FIFO. ALU results always win the port.
- A combinational hazard query lets decode stall reads of registers whose writes are still pending.

Parameters:
- XLEN, 32, data width
- AW, 5, register address width
- LQ_DEPTH, 2, LSU result queue depth; power of 2, >= 2
- CW, $clog2(LQ_DEPTH+1), occupancy counter width (derived)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- alu_valid  input  1  ALU result present this cycle; no backpressure
- alu_rd  input  AW  ALU destination register
- alu_data  input  XLEN  ALU result
- lsu_valid  input  1  LSU result offered
- lsu_ready  output  1  block accepts the LSU result this cycle
- lsu_rd  input  AW  LSU destination register
- lsu_data  input  XLEN  LSU result
- RegWEn  output  1  register file write enable (registered)
- rd_addr  output  AW  register file write address (registered)
- rd_data  output  XLEN  register file write data (registered)
- chk_addr  input  AW  decode source register being queried
- chk_hit  output  1  a write to chk_addr is pending (combinational)
- lq_count  output  CW  FIFO occupancy (registered)

Behaviour:
- Reset (rst=1 at an edge): RegWEn=0, rd_addr=0, rd_data=0, FIFO empty, lq_count=0. While rst=1, lsu_ready=0. Reset mid-operation discards all queued entries and any pending output write.
- Handshake: an LSU transfer occurs when lsu_valid && lsu_ready. lsu_ready = !rst && (lq_count != LQ_DEPTH). It depends only on registered state, so there is no combinational path from lsu_valid.
- Full FIFO: lsu_ready=0, even if a pop happens in the same cycle. No enqueue while full.
- x0 filtering:
  - alu_valid with alu_rd==0 is ignored; it does not consume the port, and the FIFO may pop that cycle.
  - An LSU transfer with lsu_rd==0 is accepted (handshake completes) but not enqueued.
- Port selection each cycle, priority order:
  1. alu_valid && alu_rd!=0: next RegWEn=1, rd_addr=alu_rd, rd_data=alu_data.
  2. Otherwise, FIFO non-empty: pop head; next RegWEn=1 with the head's rd and data.
  3. Otherwise: next RegWEn=0; rd_addr and rd_data hold their previous values.
- Latency:
  - ALU: 1 cycle (RegWEn high the edge after alu_valid).
  - LSU, without bypass: at least 2 cycles (enqueue edge, then pop edge).
- FIFO: circular buffer with read/write pointers of $clog2(LQ_DEPTH) bits that wrap modulo LQ_DEPTH. lq_count counts +1 on enqueue and -1 on pop; simultaneous enqueue and pop leaves it unchanged.
- Ordering:
  - LSU writes retire in acceptance order.
  - An ALU write may retire before older queued LSU writes. Decode must use chk_hit to prevent an ALU write to a register with a queued LSU write; the block does not reorder or detect this.
- chk_hit = (chk_addr!=0) && (any valid FIFO entry has rd==chk_addr, or (RegWEn && rd_addr==chk_addr)). The output-register term is needed because the file's read is asynchronous and that write lands only at the next edge.
- Starvation: continuous ALU traffic holds the FIFO. The queue fills and lsu_ready drops; no data is lost.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: in a cycle with the FIFO empty, no effective ALU write, and an LSU transfer with lsu_rd!=0, the LSU result goes directly to RegWEn/rd_addr/rd_data at the next edge. It never enters the FIFO: 1-cycle latency, lq_count stays 0.
- Undefined: that LSU result is enqueued and written one cycle later (2-cycle latency).
- lsu_ready is unchanged in both cases.

Test Plan:
- Reset: hold rst=1 for 2 cycles with lsu_valid=1 -> lsu_ready=0, RegWEn=0, rd_addr=0, rd_data=0, lq_count=0 throughout; after release, lsu_ready=1.
- ALU path: alu_valid=1, alu_rd=5, alu_data=0x0000_1234 for 1 cycle -> next cycle RegWEn=1, rd_addr=5, rd_data=0x1234; the following cycle RegWEn=0.
- ALU priority and backpressure: ALU writes to x1..x4 every cycle while the LSU offers rd=7/0xAAAA then rd=8/0xBBBB -> both accepted, lq_count=2, lsu_ready=0. A third LSU offer stalls. After the ALU stops, writes x7=0xAAAA then x8=0xBBBB retire on consecutive cycles.
- x0 filtering: alu_rd=0 with the FIFO holding rd=9 -> rd=9 pops that cycle. LSU transfer with lsu_rd=0 -> handshake completes, lq_count unchanged, no RegWEn.
- Hazard query: FIFO holds rd=12 -> chk_addr=12 gives chk_hit=1; chk_addr=13 gives 0; chk_addr=0 gives 0. The flag stays 1 through the cycle RegWEn=1, rd_addr=12, then drops to 0.
- Bypass and wrap: LSU rd=3/0x55 with the FIFO empty and no ALU -> RegWEn rises 1 cycle later (WB_BYPASS_EN) or 2 cycles later (without). Then push/pop 10 entries through LQ_DEPTH=2 under random ALU interference -> all LSU writes retire in order, none lost or duplicated.
